// File: rtl/fake_n64_controller_rx_pkg.sv
// Shared constants, state encoding and helpers for the Joybus receive stage.
// Timing is expressed in sample_clk cycles; one Joybus bit is four levels.
package fake_n64_controller_rx_pkg;

    localparam int unsigned LEVEL_WIDTH   = 2;
    localparam int unsigned ONE_THRESHOLD = 2 * LEVEL_WIDTH;
    localparam int unsigned MAX_LOW       = 4 * LEVEL_WIDTH;
    localparam int unsigned IDLE_TIMEOUT  = 8 * LEVEL_WIDTH;
    localparam int unsigned HIGH_CNT_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [7:0]  CRC_POLY      = 8'h85;

    localparam logic [7:0] CmdInfo   = 8'h00;
    localparam logic [7:0] CmdStatus = 8'h01;
    localparam logic [7:0] CmdRead   = 8'h02;
    localparam logic [7:0] CmdWrite  = 8'h03;
    localparam logic [7:0] CmdReset  = 8'hFF;

    localparam logic [8:0] LenShort    = 9'd8;
    localparam logic [8:0] LenRead     = 9'd24;
    localparam logic [8:0] LenWrite    = 9'd280;
    localparam logic [8:0] CmdLastBit  = 9'd7;
    localparam logic [8:0] AddrLastBit = 9'd23;
    localparam logic [8:0] CrcLastBit  = 9'd279;

    typedef enum logic [2:0] {StIdle, StLow, StHigh, StDone, StError} rx_state_e;

    function automatic logic [8:0] frame_len(input logic [7:0] cmd);
        case (cmd)
            CmdRead:                     return LenRead;
            CmdWrite:                    return LenWrite;
            CmdInfo, CmdStatus, CmdReset: return LenShort;
            default:                     return LenShort;
        endcase
    endfunction

    // Raw remainder update; the payload is not flushed with trailing zeros here.
    function automatic logic [7:0] crc_step(input logic [7:0] rem, input logic b);
        return {rem[6:0], b} ^ (rem[7] ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/fake_n64_controller_rx_if.sv
// Line-side and result signals of the Joybus receive stage.
// The slave modport is the receiver; the master drives the line and ownership.
interface fake_n64_controller_rx_if;
    logic        cur_operation;
    logic        data_rx;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  crc;
    logic        tx_handoff;
    logic        frame_err;

    modport master (
        output cur_operation, data_rx,
        input  cmd, addr, crc, tx_handoff, frame_err
    );

    modport slave (
        input  cur_operation, data_rx,
        output cmd, addr, crc, tx_handoff, frame_err
    );
endinterface

// File: rtl/fake_n64_controller_rx_joybus_bit_decoder.sv
// Synchronises the Joybus line and measures low/high pulse widths.
// Emits decoded bits on each rising edge plus framing-error and timeout flags.
module fake_n64_controller_rx_joybus_bit_decoder
    import fake_n64_controller_rx_pkg::*;
(
    input  logic sample_clk,
    input  logic reset_n,
    input  logic i_data_rx,
    input  logic i_hold,
    input  logic i_last,
    output logic o_fall,
    output logic o_bit_valid,
    output logic o_bit_value,
    output logic o_stop_seen,
    output logic o_long_low,
    output logic o_timeout
);

    logic                  r_meta;
    logic                  r_sync;
    logic                  r_prev;
    logic [3:0]            r_low_cnt;
    logic [HIGH_CNT_W-1:0] r_high_cnt;
    logic                  w_fall;
    logic                  w_rise;

    assign w_fall = r_prev & ~r_sync;
    assign w_rise = ~r_prev & r_sync;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta     <= 1'b1;
            r_sync     <= 1'b1;
            r_prev     <= 1'b1;
            r_low_cnt  <= '0;
            r_high_cnt <= '0;
        end else begin
            r_meta <= i_data_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;

            if (i_hold)                                          r_low_cnt <= '0;
            else if (w_fall)                                     r_low_cnt <= 4'd1;
            else if (r_sync)                                     r_low_cnt <= '0;
            else if (r_low_cnt != 4'd0 && r_low_cnt != 4'hF)     r_low_cnt <= r_low_cnt + 4'd1;

            // A count of zero means "not timing a pulse", so idle lines never saturate it.
            if (i_hold)                                          r_high_cnt <= '0;
            else if (w_rise)                                     r_high_cnt <= HIGH_CNT_W'(1);
            else if (!r_sync)                                    r_high_cnt <= '0;
            else if (r_high_cnt != '0 && r_high_cnt != '1)       r_high_cnt <= r_high_cnt + 1'b1;
        end
    end

    assign o_fall      = w_fall & ~i_hold;
    assign o_bit_valid = w_rise & ~i_hold;
    assign o_bit_value = r_low_cnt < 4'(ONE_THRESHOLD);
    assign o_stop_seen = o_bit_valid & i_last;
    assign o_long_low  = r_low_cnt > 4'(MAX_LOW);
    assign o_timeout   = (r_high_cnt == HIGH_CNT_W'(IDLE_TIMEOUT)) & ~w_fall;

endmodule

// File: rtl/fake_n64_controller_rx.sv
// Joybus console-to-controller receive stage: frames cmd/addr/CRC remainder
// and toggles tx_handoff when a complete frame has been received.
module fake_n64_controller_rx
    import fake_n64_controller_rx_pkg::*;
(
    input  logic                     sample_clk,
    input  logic                     reset_n,
    fake_n64_controller_rx_if.slave  bus
);

    rx_state_e   r_state, w_state_d;
    logic [8:0]  r_bit_cnt, w_bit_cnt_d;
    logic [8:0]  r_len, w_len_d;
    logic [7:0]  r_cmd_shift, w_cmd_shift_d;
    logic [15:0] r_addr_shift, w_addr_shift_d;
    logic [7:0]  r_rem, w_rem_d;
    logic [7:0]  r_cmd, w_cmd_d;
    logic [15:0] r_addr, w_addr_d;
    logic [7:0]  r_crc, w_crc_d;
    logic        r_tx_handoff;
    logic        r_frame_err;

    logic w_fall, w_bit_valid, w_bit_value, w_stop_seen, w_long_low, w_timeout;

    fake_n64_controller_rx_joybus_bit_decoder u_joybus_bit_decoder (
        .sample_clk  (sample_clk),
        .reset_n     (reset_n),
        .i_data_rx   (bus.data_rx),
        .i_hold      (bus.cur_operation),
        .i_last      (r_bit_cnt == r_len),
        .o_fall      (w_fall),
        .o_bit_valid (w_bit_valid),
        .o_bit_value (w_bit_value),
        .o_stop_seen (w_stop_seen),
        .o_long_low  (w_long_low),
        .o_timeout   (w_timeout)
    );

    always_comb begin
        w_state_d      = r_state;
        w_bit_cnt_d    = r_bit_cnt;
        w_len_d        = r_len;
        w_cmd_shift_d  = r_cmd_shift;
        w_addr_shift_d = r_addr_shift;
        w_rem_d        = r_rem;
        w_cmd_d        = r_cmd;
        w_addr_d       = r_addr;
        w_crc_d        = r_crc;

        if (bus.cur_operation) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_fall) begin
                        w_state_d   = StLow;
                        w_bit_cnt_d = '0;
                        w_len_d     = LenShort;
                        w_rem_d     = '0;
                    end
                end
                StLow: begin
                    if (w_long_low) begin
                        w_state_d = StError;
                    end else if (w_stop_seen) begin
                        w_state_d = StDone;
                    end else if (w_bit_valid) begin
                        w_state_d   = StHigh;
                        w_bit_cnt_d = r_bit_cnt + 9'd1;
                        // Visible outputs only change at the last bit of each field.
                        if (r_bit_cnt <= CmdLastBit) begin
                            w_cmd_shift_d = {r_cmd_shift[6:0], w_bit_value};
                            if (r_bit_cnt == CmdLastBit) begin
                                w_cmd_d = w_cmd_shift_d;
                                w_len_d = frame_len(w_cmd_shift_d);
                            end
                        end else if (r_bit_cnt <= AddrLastBit) begin
                            w_addr_shift_d = {r_addr_shift[14:0], w_bit_value};
                            if (r_bit_cnt == AddrLastBit) w_addr_d = w_addr_shift_d;
                        end else begin
                            w_rem_d = crc_step(r_rem, w_bit_value);
                            if (r_bit_cnt == CrcLastBit) w_crc_d = w_rem_d;
                        end
                    end
                end
                StHigh: begin
                    if (w_fall)         w_state_d = StLow;
                    else if (w_timeout) w_state_d = StError;
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_bit_cnt    <= '0;
            r_len        <= '0;
            r_cmd_shift  <= '0;
            r_addr_shift <= '0;
            r_rem        <= '0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_crc        <= '0;
            r_tx_handoff <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_len        <= w_len_d;
            r_cmd_shift  <= w_cmd_shift_d;
            r_addr_shift <= w_addr_shift_d;
            r_rem        <= w_rem_d;
            r_cmd        <= w_cmd_d;
            r_addr       <= w_addr_d;
            r_crc        <= w_crc_d;
            r_tx_handoff <= r_tx_handoff ^ (w_state_d == StDone);
            r_frame_err  <= (w_state_d == StError);
        end
    end

    assign bus.cmd        = r_cmd;
    assign bus.addr       = r_addr;
    assign bus.crc        = r_crc;
    assign bus.tx_handoff = r_tx_handoff;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_fake_n64_controller_rx.sv
// Directed bench for the Joybus receive stage: frames are driven as pulse
// widths and completed/aborted frames are checked against a scoreboard.
module tb_fake_n64_controller_rx;

    localparam logic [7:0] Poly = 8'h85;

    typedef struct {
        logic        is_err;
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  crc;
    } exp_t;

    logic sample_clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    logic [7:0]  m_cmd;
    logic [15:0] m_addr;
    logic [7:0]  m_crc;

    fake_n64_controller_rx_if bus ();

    fake_n64_controller_rx dut (
        .sample_clk (sample_clk),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    initial begin
        sample_clk = 1'b0;
        forever #5 sample_clk = ~sample_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_step_m(input logic [7:0] rem, input logic b);
        return {rem[6:0], b} ^ (rem[7] ? Poly : 8'h00);
    endfunction

    // Conventional bytewise CRC-8, equivalent to the remainder flushed with 8 zeros.
    function automatic logic [7:0] crc_ref_payload();
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 32; i++) begin
            c = c ^ 8'(i);
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ Poly) : (c << 1);
        end
        return c;
    endfunction

    task automatic hold(input logic v, input int n);
        bus.data_rx = v;
        repeat (n) @(negedge sample_clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin hold(1'b0, 2); hold(1'b1, 6); end
        else   begin hold(1'b0, 6); hold(1'b1, 2); end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_stop();
        hold(1'b0, 2);
        hold(1'b1, 6);
    endtask

    task automatic push_exp(input logic is_err);
        exp_t e;
        e.is_err = is_err;
        e.cmd    = m_cmd;
        e.addr   = m_addr;
        e.crc    = m_crc;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge sample_clk);
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : mon
        logic h_prev;
        logic e_prev;
        exp_t e;
        h_prev = 1'b0;
        e_prev = 1'b0;
        forever begin
            @(negedge sample_clk);
            if (!reset_n) begin
                h_prev = bus.tx_handoff;
                e_prev = 1'b0;
            end else begin
                if (e_prev) check("frame_err_width", 32'(bus.frame_err), 32'd0);
                if (bus.tx_handoff !== h_prev || bus.frame_err === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_event", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("event_kind", 32'(bus.frame_err), 32'(e.is_err));
                        check("event_cmd", 32'(bus.cmd), 32'(e.cmd));
                        check("event_addr", 32'(bus.addr), 32'(e.addr));
                        check("event_crc", 32'(bus.crc), 32'(e.crc));
                    end
                end
                e_prev = bus.frame_err;
                h_prev = bus.tx_handoff;
            end
        end
    end

    initial begin : stim
        logic       h0;
        logic       h1;
        logic [7:0] r;
        logic [7:0] pb;

        bus.data_rx       = 1'b1;
        bus.cur_operation = 1'b0;
        reset_n           = 1'b0;
        m_cmd  = '0;
        m_addr = '0;
        m_crc  = '0;
        repeat (2) @(negedge sample_clk);
        check("reset_cmd", 32'(bus.cmd), 32'd0);
        check("reset_addr", 32'(bus.addr), 32'd0);
        check("reset_crc", 32'(bus.crc), 32'd0);
        check("reset_handoff", 32'(bus.tx_handoff), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        reset_n = 1'b1;
        hold(1'b1, 4);

        // INFO with stop-bit latency measured from the line's rising edge
        m_cmd = 8'h00;
        push_exp(1'b0);
        send_byte(8'h00);
        hold(1'b0, 2);
        bus.data_rx = 1'b1;
        h0 = bus.tx_handoff;
        h1 = ~h0;
        repeat (2) @(negedge sample_clk);
        check("info_handoff_early", 32'(bus.tx_handoff), 32'(h0));
        @(negedge sample_clk);
        check("info_handoff_3cyc", 32'(bus.tx_handoff), 32'(h1));
        hold(1'b1, 8);
        drain("info_drain");
        check("info_no_err", 32'(bus.frame_err), 32'd0);

        // READ: crc keeps its prior value
        m_cmd  = 8'h02;
        m_addr = 16'h8001;
        push_exp(1'b0);
        send_byte(8'h02);
        send_byte(8'h80);
        send_byte(8'h01);
        send_stop();
        hold(1'b1, 4);
        drain("read_drain");

        // WRITE with 32-byte payload 0x00..0x1F
        m_cmd  = 8'h03;
        m_addr = 16'hC01B;
        m_crc  = 8'h00;
        for (int i = 0; i < 32; i++) begin
            pb = 8'(i);
            for (int k = 7; k >= 0; k--) m_crc = crc_step_m(m_crc, pb[k]);
        end
        push_exp(1'b0);
        send_byte(8'h03);
        send_byte(8'hC0);
        send_byte(8'h1B);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        send_stop();
        hold(1'b1, 4);
        drain("write_drain");
        r = bus.crc;
        for (int k = 0; k < 8; k++) r = crc_step_m(r, 1'b0);
        check("crc_flush_ref", 32'(r), 32'(crc_ref_payload()));

        // Timeout after 5 address bits: outputs keep the WRITE values
        push_exp(1'b1);
        send_byte(8'h03);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        hold(1'b1, 40);
        drain("timeout_drain");

        // 9-cycle low at bit 3, then a valid STATUS frame
        push_exp(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        hold(1'b0, 9);
        hold(1'b1, 20);
        drain("longlow_drain");
        m_cmd = 8'h01;
        push_exp(1'b0);
        send_byte(8'h01);
        send_stop();
        hold(1'b1, 4);
        drain("status_drain");

        // Asynchronous reset during data bit 100 of a WRITE
        send_byte(8'h03);
        send_byte(8'hC0);
        send_byte(8'h1B);
        for (int i = 0; i < 76; i++) begin
            pb = 8'(i / 8);
            send_bit(pb[7 - (i % 8)]);
        end
        bus.data_rx = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_cmd", 32'(bus.cmd), 32'd0);
        check("midreset_addr", 32'(bus.addr), 32'd0);
        check("midreset_crc", 32'(bus.crc), 32'd0);
        check("midreset_handoff", 32'(bus.tx_handoff), 32'd0);
        check("midreset_frame_err", 32'(bus.frame_err), 32'd0);
        m_cmd  = '0;
        m_addr = '0;
        m_crc  = '0;
        bus.data_rx = 1'b1;
        repeat (3) @(negedge sample_clk);
        reset_n = 1'b1;
        hold(1'b1, 4);

        // Tx takes the line mid-frame; a whole frame while Tx owns it is ignored
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        bus.cur_operation = 1'b1;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_byte(8'h01);
        send_stop();
        hold(1'b1, 10);
        check("curop_cmd", 32'(bus.cmd), 32'(m_cmd));
        check("curop_handoff", 32'(bus.tx_handoff), 32'd0);
        bus.cur_operation = 1'b0;
        hold(1'b1, 20);
        m_cmd = 8'hFF;
        push_exp(1'b0);
        send_byte(8'hFF);
        send_stop();
        hold(1'b1, 4);
        drain("reset_cmd_drain");

        hold(1'b1, 10);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
